// File: rtl/struct_pckg.sv
// Shared structures and enums for the core interconnect and the IM loader.
`include "defines.sv"

package struct_pckg;

  typedef struct packed {
    logic [`IM_DATA_BYTES-1:0] we_im;
    logic [`RNG_32]            im_data;
  } interconnection_struct;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_HDR,
    LD_PAYLOAD,
    LD_CHK,
    LD_DONE,
    LD_ERR
  } loader_state_e;

  typedef enum logic [1:0] {
    LD_ERR_NONE    = 2'd0,
    LD_ERR_COUNT   = 2'd1,
    LD_ERR_CHKSUM  = 2'd2,
    LD_ERR_TIMEOUT = 2'd3
  } loader_err_e;

endpackage

// File: rtl/defines.sv
// Project-wide macros shared by the core and its boot-time loader.
`ifndef RIVIERA_DEFINES_SV
`define RIVIERA_DEFINES_SV

`define IM_DATA_BYTES 4
`define RNG_32 31:0
`define IM_LOADER_TIMEOUT 65535

`endif

// File: rtl/im_loader_timer.sv
// Saturating idle-cycle counter; flags the cycle on which it would reach the limit.
`include "defines.sv"

module im_loader_timer #(
  parameter int unsigned TIMEOUT_CYC = `IM_LOADER_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

  logic [CW-1:0] count_q;

  // Count idle cycles while enabled; an accepted byte or leaving the active states restarts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear || !enable) begin
      count_q <= '0;
    end else if (count_q != LIMIT) begin
      count_q <= count_q + 1'b1;
    end
  end

  // A clear in the same cycle suppresses expiry, so a last-moment byte wins
  assign expired = enable && !clear && (count_q >= LIMIT - CW'(1));

endmodule

// File: rtl/riviera_im_loader.sv
// Boot loader: framed byte stream -> sequential 32-bit IM writes, core held in reset until verified.
`include "defines.sv"

module riviera_im_loader
  import struct_pckg::*;
#(
  parameter int unsigned IM_WORDS    = 1024,
  parameter int unsigned TIMEOUT_CYC = `IM_LOADER_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_byte_valid,
  input  logic [7:0]                i_byte,
  output logic                      o_byte_ready,
  input  logic                      i_restart,
  output logic [`IM_DATA_BYTES-1:0] o_we_im,
  output logic [`RNG_32]            o_im_data,
  output logic                      o_core_rst_n,
  output logic                      o_done,
  output logic                      o_err,
  output logic [1:0]                o_err_code
);

  localparam int WCW = $clog2(IM_WORDS + 1);

  loader_state_e state_q, state_d;
  loader_err_e   err_code_q, err_code_d;

  logic [1:0]     byte_idx_q;
  logic [31:0]    count_q;
  logic [WCW-1:0] word_cnt_q;
  logic [23:0]    word_q;
  logic [7:0]     xor_q;
  logic           we_q;
  logic [31:0]    data_q;

  logic        accept;
  logic        timer_en;
  logic        timer_expired;
  logic [31:0] hdr_count;
  logic        last_word;

  assign o_byte_ready = (state_q == LD_IDLE) || (state_q == LD_HDR) ||
                        (state_q == LD_PAYLOAD) || (state_q == LD_CHK);
  assign accept       = i_byte_valid && o_byte_ready;
  assign timer_en     = (state_q == LD_HDR) || (state_q == LD_PAYLOAD) || (state_q == LD_CHK);

  // Fields arrive little-endian, so bytes shift in from the top
  assign hdr_count = {i_byte, count_q[31:8]};
  assign last_word = (32'(word_cnt_q) + 32'd1) == count_q;

  im_loader_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (timer_en),
    .clear  (accept),
    .expired(timer_expired)
  );

  // State and error-code registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LD_IDLE;
      err_code_q <= LD_ERR_NONE;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
    end
  end

  // Next-state and state-decoded status outputs
  always_comb begin
    state_d      = state_q;
    err_code_d   = err_code_q;
    o_done       = 1'b0;
    o_core_rst_n = 1'b0;
    o_err        = 1'b0;
    case (state_q)
      LD_IDLE: begin
        if (accept) state_d = LD_HDR;
      end
      LD_HDR: begin
        if (accept && byte_idx_q == 2'd3) begin
          if (hdr_count == 32'd0 || hdr_count > 32'(IM_WORDS)) begin
            state_d    = LD_ERR;
            err_code_d = LD_ERR_COUNT;
          end else begin
            state_d = LD_PAYLOAD;
          end
        end else if (timer_expired) begin
          state_d    = LD_ERR;
          err_code_d = LD_ERR_TIMEOUT;
        end
      end
      LD_PAYLOAD: begin
        if (accept && byte_idx_q == 2'd3 && last_word) begin
          state_d = LD_CHK;
        end else if (timer_expired) begin
          state_d    = LD_ERR;
          err_code_d = LD_ERR_TIMEOUT;
        end
      end
      LD_CHK: begin
        if (accept) begin
          if (i_byte == xor_q) begin
            state_d = LD_DONE;
          end else begin
            state_d    = LD_ERR;
            err_code_d = LD_ERR_CHKSUM;
          end
        end else if (timer_expired) begin
          state_d    = LD_ERR;
          err_code_d = LD_ERR_TIMEOUT;
        end
      end
      LD_DONE: begin
        o_done       = 1'b1;
        o_core_rst_n = 1'b1;
        if (i_restart) state_d = LD_IDLE;
      end
      LD_ERR: begin
        o_err = 1'b1;
        if (i_restart) begin
          state_d    = LD_IDLE;
          err_code_d = LD_ERR_NONE;
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

  // Header/word assembly, checksum accumulation and the one-cycle write pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_q <= 2'd0;
      count_q    <= '0;
      word_cnt_q <= '0;
      word_q     <= '0;
      xor_q      <= '0;
      we_q       <= 1'b0;
      data_q     <= '0;
    end else begin
      we_q <= 1'b0;
      if (accept) begin
        case (state_q)
          LD_IDLE: begin
            count_q    <= {i_byte, 24'd0};
            byte_idx_q <= 2'd1;
            word_cnt_q <= '0;
            xor_q      <= '0;
          end
          LD_HDR: begin
            count_q    <= hdr_count;
            byte_idx_q <= byte_idx_q + 2'd1;
          end
          LD_PAYLOAD: begin
            word_q     <= {i_byte, word_q[23:8]};
            xor_q      <= xor_q ^ i_byte;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              we_q       <= 1'b1;
              data_q     <= {i_byte, word_q};
              word_cnt_q <= word_cnt_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_we_im    = {`IM_DATA_BYTES{we_q}};
  assign o_im_data  = data_q;
  assign o_err_code = err_code_q;

endmodule

// File: tb/tb_riviera_im_loader.sv
// Directed and randomized frames against a frame-level reference model of the loader.
module tb_riviera_im_loader;

  localparam int unsigned IM_WORDS = 1024;
  localparam int unsigned TO_CYC   = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_byte_valid = 1'b0;
  logic [7:0]  i_byte = 8'h00;
  logic        i_restart = 1'b0;
  logic        o_byte_ready;
  logic [3:0]  o_we_im;
  logic [31:0] o_im_data;
  logic        o_core_rst_n;
  logic        o_done;
  logic        o_err;
  logic [1:0]  o_err_code;

  int tests = 0;
  int fails = 0;
  logic [31:0] wr_q[$];

  riviera_im_loader #(
    .IM_WORDS   (IM_WORDS),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_byte_valid(i_byte_valid),
    .i_byte      (i_byte),
    .o_byte_ready(o_byte_ready),
    .i_restart   (i_restart),
    .o_we_im     (o_we_im),
    .o_im_data   (o_im_data),
    .o_core_rst_n(o_core_rst_n),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_err_code  (o_err_code)
  );

  always #5 clk = ~clk;

  // Record every write the memory would see
  always @(negedge clk) begin
    if (o_we_im !== 4'h0) wr_q.push_back(o_im_data);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame bytes from the protocol definition: LE count, LE words, XOR of payload
  function automatic void build_frame(input int unsigned n, input logic [31:0] w[$],
                                      input bit corrupt, output logic [7:0] f[$]);
    logic [7:0] x;
    x = 8'h00;
    f = {};
    for (int k = 0; k < 4; k++) f.push_back(8'(n >> (8 * k)));
    foreach (w[i]) begin
      for (int k = 0; k < 4; k++) begin
        f.push_back(8'(w[i] >> (8 * k)));
        x ^= 8'(w[i] >> (8 * k));
      end
    end
    f.push_back(corrupt ? (x ^ 8'h01) : x);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, " we"}, 32'(o_we_im), 32'h0);
    check({tag, " data"}, o_im_data, 32'h0);
    check({tag, " core_rst_n"}, 32'(o_core_rst_n), 32'h0);
    check({tag, " done"}, 32'(o_done), 32'h0);
    check({tag, " err"}, 32'(o_err), 32'h0);
    check({tag, " code"}, 32'(o_err_code), 32'h0);
  endtask

  // Present one byte until accepted, then check the write port on the following cycle
  task automatic send_byte(input logic [7:0] b, input bit exp_we, input logic [31:0] exp_word);
    bit rdy;
    int waits;
    waits = 0;
    i_byte_valid = 1'b1;
    i_byte = b;
    forever begin
      rdy = o_byte_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      waits++;
      if (waits > 50) begin
        check("byte accept wait", 32'h0, 32'h1);
        i_byte_valid = 1'b0;
        return;
      end
    end
    i_byte_valid = 1'b0;
    check("we after byte", 32'(o_we_im), exp_we ? 32'hF : 32'h0);
    if (exp_we) check("write data", o_im_data, exp_word);
  endtask

  task automatic idle_cycles(input int n);
    i_byte_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_restart();
    i_restart = 1'b1;
    @(posedge clk);
    #1;
    i_restart = 1'b0;
    check("restart core_rst_n", 32'(o_core_rst_n), 32'h0);
    check("restart done", 32'(o_done), 32'h0);
    check("restart err", 32'(o_err), 32'h0);
    check("restart code", 32'(o_err_code), 32'h0);
    check("restart ready", 32'(o_byte_ready), 32'h1);
  endtask

  // Send a whole frame with optional random stalls and check the outcome
  task automatic run_frame(input int unsigned n, input logic [31:0] w[$], input bit corrupt,
                           input int max_stall);
    logic [7:0] f[$];
    int base, nsend, nwr;
    bit bad, we_exp;
    logic [31:0] wexp;
    base = wr_q.size();
    build_frame(n, w, corrupt, f);
    bad = (n == 0) || (n > IM_WORDS);
    nsend = bad ? 4 : f.size();
    for (int i = 0; i < nsend; i++) begin
      if (max_stall > 0) idle_cycles($urandom_range(max_stall, 0));
      we_exp = !bad && (i >= 4) && (i < 4 + 4 * int'(n)) && (((i - 4) % 4) == 3);
      wexp = (i >= 3) ? {f[i], f[i-1], f[i-2], f[i-3]} : 32'h0;
      send_byte(f[i], we_exp, wexp);
    end
    nwr = wr_q.size() - base;
    if (bad) begin
      check("badcount err", 32'(o_err), 32'h1);
      check("badcount code", 32'(o_err_code), 32'h1);
      check("badcount ready", 32'(o_byte_ready), 32'h0);
      check("badcount writes", 32'(nwr), 32'h0);
    end else begin
      check("write count", 32'(nwr), 32'(n));
      for (int i = 0; i < int'(n) && i < nwr; i++) check("write word", wr_q[base + i], w[i]);
      if (corrupt) begin
        check("chk err", 32'(o_err), 32'h1);
        check("chk code", 32'(o_err_code), 32'h2);
        check("chk core_rst_n", 32'(o_core_rst_n), 32'h0);
        check("chk done", 32'(o_done), 32'h0);
      end else begin
        check("load done", 32'(o_done), 32'h1);
        check("load core_rst_n", 32'(o_core_rst_n), 32'h1);
        check("load err", 32'(o_err), 32'h0);
        check("load ready", 32'(o_byte_ready), 32'h0);
      end
    end
  endtask

  initial begin
    logic [31:0] good[$];
    logic [31:0] none[$];
    logic [31:0] rw[$];
    logic [7:0]  f[$];
    int base;
    int unsigned n;
    bit corrupt;

    good = '{32'h0000_0013, 32'h00A0_0093};
    none = {};

    // Reset state
    #12;
    check_reset_outputs("reset");
    check("reset ready", 32'(o_byte_ready), 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(2);

    // Spec frame and its checksum value
    build_frame(2, good, 1'b0, f);
    check("good checksum byte", 32'(f[12]), 32'h20);
    run_frame(2, good, 1'b0, 0);
    pulse_restart();

    // Bad counts
    run_frame(0, none, 1'b0, 0);
    pulse_restart();
    run_frame(IM_WORDS + 1, none, 1'b0, 0);
    pulse_restart();

    // Checksum mismatch
    run_frame(2, good, 1'b1, 0);
    pulse_restart();

    // Timeout: 5 bytes then a full stall
    build_frame(2, good, 1'b0, f);
    for (int i = 0; i < 5; i++) send_byte(f[i], 1'b0, 32'h0);
    idle_cycles(TO_CYC - 1);
    check("timeout early err", 32'(o_err), 32'h0);
    idle_cycles(1);
    check("timeout err", 32'(o_err), 32'h1);
    check("timeout code", 32'(o_err_code), 32'h3);
    check("timeout ready", 32'(o_byte_ready), 32'h0);
    pulse_restart();

    // Timeout averted by a byte on the last allowed cycle
    base = wr_q.size();
    for (int i = 0; i < 5; i++) send_byte(f[i], 1'b0, 32'h0);
    idle_cycles(TO_CYC - 1);
    for (int i = 5; i < f.size(); i++)
      send_byte(f[i], (i == 7) || (i == 11), {f[i], f[i-1], f[i-2], f[i-3]});
    check("avert err", 32'(o_err), 32'h0);
    check("avert done", 32'(o_done), 32'h1);
    check("avert writes", 32'(wr_q.size() - base), 32'h2);
    pulse_restart();

    // Asynchronous reset mid-payload
    base = wr_q.size();
    for (int i = 0; i < 10; i++) send_byte(f[i], i == 7, {f[i], f[i-1], f[i-2], f[i-3]});
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(5);
    check("midreset writes", 32'(wr_q.size() - base), 32'h1);
    check("midreset core_rst_n", 32'(o_core_rst_n), 32'h0);

    // Load, restart from DONE, load again
    run_frame(2, good, 1'b0, 0);
    pulse_restart();
    run_frame(2, good, 1'b0, 0);
    pulse_restart();

    // Backpressure on the spec frame
    run_frame(2, good, 1'b0, 3);
    pulse_restart();

    // Random frames with random stalls and occasional bad checksum
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(6, 1);
      rw = {};
      for (int k = 0; k < int'(n); k++) rw.push_back($urandom);
      corrupt = ($urandom_range(3, 0) == 0);
      run_frame(n, rw, corrupt, 3);
      pulse_restart();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
